stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 28 ++
 rtl/md_busy_timer.sv | 64 ++++++
 rtl/stall_ctrl.sv | 70 +++++++
 tb/tb_stall_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline-control constants for the hazard/stall unit: register-file
// addressing, stall counter limits, HI/LO sequencer state and operation encodings.
package stall_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam int STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef enum logic {
    MD_OP_MULT = 1'b0,
    MD_OP_DIV  = 1'b1
  } md_op_t;

  // Counter must hold the longer of the two latencies.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO occupancy sequencer: after an accepted Start, Busy stays high for exactly
// MULT_CYCLES or DIV_CYCLES cycles. Starts arriving while busy are dropped.
import stall_ctrl_pkg::*;

module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic Op,
  output logic Busy,
  output logic State
);

  localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MD_IDLE: begin
        if (Start) begin
          state_next = MD_BUSY;
          cnt_next   = (md_op_t'(Op) == MD_OP_DIV) ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // The cycle holding count 1 is the last busy cycle.
        if (cnt == CNT_LAST) begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_LAST;
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign Busy  = (state == MD_BUSY);
  assign State = state;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard unit: load-use, branch-operand and HI/LO-busy hazards combine
// into one stall that holds F/D and bubbles D/E; stalled cycles are counted.
import stall_ctrl_pkg::*;

module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        UseRsD,
  input  logic        UseRtD,
  input  logic        BranchD,
  input  logic        MemReadE,
  input  logic        RegWriteE,
  input  logic [4:0]  WriteRegE,
  input  logic        MdStartE,
  input  logic        MdOpE,
  input  logic        MdUseD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        MdBusy,
  output logic [31:0] StallCnt,
  output logic        MdState
);

  logic        rs_match, rt_match, dest_live;
  logic        load_use, branch_haz, md_haz, stall;
  logic [31:0] stall_cnt_q;

  // $0 is never a real producer, so it can never create a dependency.
  assign dest_live  = (WriteRegE != REG_ZERO);
  assign rs_match   = UseRsD && (RsD == WriteRegE);
  assign rt_match   = UseRtD && (RtD == WriteRegE);

  assign load_use   = MemReadE && dest_live && (rs_match || rt_match);
  assign branch_haz = BranchD && RegWriteE && dest_live && (rs_match || rt_match);
  assign md_haz     = MdUseD && (MdBusy || MdStartE);
  assign stall      = load_use || branch_haz || md_haz;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (MdStartE),
    .Op    (MdOpE),
    .Busy  (MdBusy),
    .State (MdState)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: a cycle-indexed reference model checked every
// cycle, plus hand-computed pinned expectations queued by the driver.
module tb_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

  // ---------------- clock / reset ----------------
  logic        Clk;
  logic        Reset;
  logic [4:0]  RsD, RtD, WriteRegE;
  logic        UseRsD, UseRtD, BranchD, MemReadE, RegWriteE;
  logic        MdStartE, MdOpE, MdUseD;
  logic        StallF, StallD, FlushE, MdBusy, MdState;
  logic [31:0] StallCnt;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .UseRsD    (UseRsD),
    .UseRtD    (UseRtD),
    .BranchD   (BranchD),
    .MemReadE  (MemReadE),
    .RegWriteE (RegWriteE),
    .WriteRegE (WriteRegE),
    .MdStartE  (MdStartE),
    .MdOpE     (MdOpE),
    .MdUseD    (MdUseD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .MdBusy    (MdBusy),
    .StallCnt  (StallCnt),
    .MdState   (MdState)
  );

  // ---------------- reference model ----------------
  // HI/LO occupancy is modelled as a window of cycle indices after the issue edge.
  int          m_cyc      = 0;
  int          m_busy_end = -1;
  logic [31:0] m_cnt      = '0;
  int          preset_seq = 0;
  int          preset_seen = 0;
  logic [31:0] preset_val = '0;

  function automatic logic model_busy();
    return (m_cyc <= m_busy_end);
  endfunction

  function automatic logic model_stall();
    logic dep, lu, bh, mh;
    dep = (WriteRegE != 5'd0) &&
          ((UseRsD && RsD == WriteRegE) || (UseRtD && RtD == WriteRegE));
    lu  = MemReadE && dep;
    bh  = BranchD && RegWriteE && dep;
    mh  = MdUseD && (model_busy() || MdStartE);
    return lu || bh || mh;
  endfunction

  always @(posedge Clk or posedge Reset or preset_seq) begin
    if (Reset) begin
      m_cnt      = '0;
      m_busy_end = m_cyc - 1;
    end else if (preset_seq != preset_seen) begin
      preset_seen = preset_seq;
      m_cnt       = preset_val;
    end else if (Clk) begin
      if (model_stall() && m_cnt != CNT_MAX) m_cnt = m_cnt + 32'd1;
      if (MdStartE && !model_busy()) m_busy_end = m_cyc + (MdOpE ? DIV_N : MULT_N);
      m_cyc = m_cyc + 1;
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {pin_en, stall, busy, stall_cnt}, one per driven cycle.
  logic [34:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, m_cyc, act, exp);
    end
  endtask

  always begin
    logic [34:0] pin;
    logic        s_exp, b_exp;
    @(negedge Clk);
    #2;
    s_exp = model_stall();
    b_exp = model_busy();
    chk("stallf", {31'd0, StallF}, {31'd0, s_exp});
    chk("stalld", {31'd0, StallD}, {31'd0, s_exp});
    chk("flushe", {31'd0, FlushE}, {31'd0, s_exp});
    chk("mdbusy", {31'd0, MdBusy}, {31'd0, b_exp});
    chk("mdstate", {31'd0, MdState}, {31'd0, b_exp});
    chk("stallcnt", StallCnt, m_cnt);
    if (exp_q.size() != 0) begin
      pin = exp_q.pop_front();
      if (pin[34]) begin
        chk("pin_stall", {31'd0, StallF}, {31'd0, pin[33]});
        chk("pin_busy", {31'd0, MdBusy}, {31'd0, pin[32]});
        chk("pin_cnt", StallCnt, pin[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    RsD = 5'd0; RtD = 5'd0; UseRsD = 1'b0; UseRtD = 1'b0;
    BranchD = 1'b0; MemReadE = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0;
    MdStartE = 1'b0; MdOpE = 1'b0; MdUseD = 1'b0;
  endtask

  task automatic load_use_rs8();
    MemReadE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
  endtask

  task automatic cyc(input logic en, input logic ps, input logic pb, input logic [31:0] pc);
    exp_q.push_back({en, ps, pb, pc});
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    @(negedge Clk);

    // reset: outputs idle, then hazards stay combinational during reset
    cyc(1, 0, 0, 32'd0);
    load_use_rs8();
    cyc(1, 1, 0, 32'd0);
    Reset = 1'b0; idle();
    cyc(1, 0, 0, 32'd0);

    // load-use and $0 exclusion
    idle(); load_use_rs8();
    cyc(1, 1, 0, 32'd0);
    idle(); MemReadE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0; UseRsD = 1'b1;
    cyc(1, 0, 0, 32'd1);
    idle(); MemReadE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8; RtD = 5'd8; UseRtD = 1'b1;
    cyc(1, 1, 0, 32'd1);
    idle(); MemReadE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    cyc(1, 0, 0, 32'd2);

    // branch operand hazard
    idle(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RtD = 5'd5; UseRtD = 1'b1;
    cyc(1, 1, 0, 32'd2);
    BranchD = 1'b0;
    cyc(1, 0, 0, 32'd3);
    BranchD = 1'b1; RegWriteE = 1'b0;
    cyc(1, 0, 0, 32'd3);
    RegWriteE = 1'b1; WriteRegE = 5'd0; RtD = 5'd0;
    cyc(1, 0, 0, 32'd3);

    // multiply timing with a waiting HI/LO user
    idle(); MdStartE = 1'b1; MdUseD = 1'b1;
    cyc(1, 1, 0, 32'd3);
    for (int i = 1; i <= MULT_N; i++) begin
      idle(); MdUseD = 1'b1;
      cyc(1, 1, 1, 32'd3 + 32'(i));
    end
    idle(); MdUseD = 1'b1;
    cyc(1, 0, 0, 32'd9);
    idle();
    cyc(1, 0, 0, 32'd9);

    // load-use overlapping HI/LO hazard counts once; start while busy is ignored
    idle(); MdStartE = 1'b1;
    cyc(1, 0, 0, 32'd9);
    idle(); MdUseD = 1'b1; load_use_rs8();
    cyc(1, 1, 1, 32'd9);
    idle(); MdStartE = 1'b1; MdOpE = 1'b1;
    cyc(1, 0, 1, 32'd10);
    idle();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'd10);
    cyc(1, 0, 0, 32'd10);

    // divide aborted by reset, then a fresh multiply
    idle(); MdStartE = 1'b1; MdOpE = 1'b1;
    cyc(1, 0, 0, 32'd10);
    idle();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'd10);
    Reset = 1'b1;
    cyc(1, 0, 0, 32'd0);
    Reset = 1'b0;
    cyc(1, 0, 0, 32'd0);
    MdStartE = 1'b1;
    cyc(1, 0, 0, 32'd0);
    idle();
    for (int i = 0; i < MULT_N; i++) cyc(1, 0, 1, 32'd0);
    cyc(1, 0, 0, 32'd0);

    // full divide latency
    MdStartE = 1'b1; MdOpE = 1'b1;
    cyc(1, 0, 0, 32'd0);
    idle();
    for (int i = 0; i < DIV_N; i++) cyc(1, 0, 1, 32'd0);
    cyc(1, 0, 0, 32'd0);

    // saturation of the stall counter
    idle(); load_use_rs8();
    force dut.stall_cnt_q = 32'hFFFFFFFD;
    preset_val = 32'hFFFFFFFD;
    preset_seq = preset_seq + 1;
    #1;
    release dut.stall_cnt_q;
    cyc(1, 1, 0, 32'hFFFFFFFD);
    cyc(1, 1, 0, 32'hFFFFFFFE);
    cyc(1, 1, 0, 32'hFFFFFFFF);
    cyc(1, 1, 0, 32'hFFFFFFFF);
    idle();
    cyc(1, 0, 0, 32'hFFFFFFFF);

    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
